// File: rtl/accum_seq.sv
// Purpose : repeat-add sequencer; clears the accumulator, then adds a captured addend into it N times.
// Latency : result presented N+1 edges after an accepted start (1 edge when N=0); held until acknowledged.
// Backpr. : one job at a time; start is honoured only in IDLE, so the requester waits for DONE/ACK.
//
// Ports:
//   i_ck     clock, all state changes on the rising edge
//   i_clr    synchronous active-high reset; aborts any job in progress
//   i_start  job request, sampled only in IDLE
//   i_a      addend, captured with an accepted start
//   i_n      repeat count, captured with an accepted start
//   i_ack    result consumed, sampled only in HOLD
//   o_busy   high while adding (RUN)
//   o_done   high while the result is presented (HOLD)
//   o_q      accumulator contents, meaningful while o_done=1
//   o_ovf    sticky carry-out of the current job, meaningful while o_done=1
module accum_seq #(
    parameter int WIDTH  = 16,
    parameter int CWIDTH = 8
) (
    input  logic              i_ck,
    input  logic              i_clr,
    input  logic              i_start,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [CWIDTH-1:0] i_n,
    input  logic              i_ack,
    output logic              o_busy,
    output logic              o_done,
    output logic [WIDTH-1:0]  o_q,
    output logic              o_ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_a;
    logic [CWIDTH-1:0] r_cnt;
    logic              r_ovf;

    // One extra bit catches the carry-out of every add.
    logic [WIDTH:0]    w_sum;
    logic              w_last;
    logic              w_accept;

    assign w_sum    = {1'b0, r_acc} + {1'b0, r_a};
    assign w_last   = (r_cnt == CWIDTH'(1));
    assign w_accept = (r_state == S_IDLE) && i_start;

    // Next-state decode. A zero count skips RUN entirely, which is what
    // keeps the down-counter from ever wrapping below zero.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_n != '0) ? S_RUN : S_HOLD;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // START is deliberately not looked at here, even together
                // with ACK: a new job needs a fresh request from IDLE.
                if (i_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_ck) begin
        if (i_clr) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_a     <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a   <= i_a;
                r_cnt <= i_n;
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_sum[WIDTH-1:0];
                r_ovf <= r_ovf | w_sum[WIDTH];
                r_cnt <= r_cnt - CWIDTH'(1);
            end
            // IDLE without start and HOLD: everything frozen, so Q keeps
            // showing the last result after it has been acknowledged.
        end
    end

    // Outputs come straight from registers; no input reaches an output
    // without passing through a flop.
    assign o_busy = (r_state == S_RUN);
    assign o_done = (r_state == S_HOLD);
    assign o_q    = r_acc;
    assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_accum_seq.sv
module tb_accum_seq;

    typedef struct packed {
        logic [15:0] q;
        logic        ovf;
        logic [8:0]  busy;
    } exp_t;

    logic        ck;
    logic        clr;
    logic        start;
    logic [15:0] a;
    logic [7:0]  n;
    logic        ack;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];

    accum_seq #(.WIDTH(16), .CWIDTH(8)) dut (
        .i_ck    (ck),
        .i_clr   (clr),
        .i_start (start),
        .i_a     (a),
        .i_n     (n),
        .i_ack   (ack),
        .o_busy  (busy),
        .o_done  (done),
        .o_q     (q),
        .o_ovf   (ovf)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // ---------------- monitor / scoreboard ----------------
    int   busy_cnt = 0;
    bit   in_done  = 0;
    bit   have_cur = 0;
    exp_t cur;

    always @(negedge ck) begin
        if (clr) begin
            busy_cnt = 0;
            in_done  = 0;
            have_cur = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (!in_done) begin
                    in_done = 1;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        have_cur = 0;
                        $display("FAIL unexpected_done: DONE rose with no job outstanding (q=%h ovf=%b)", q, ovf);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1;
                        if (busy_cnt != int'(cur.busy)) begin
                            failures++;
                            $display("FAIL busy_cycles: got %0d want %0d", busy_cnt, cur.busy);
                        end
                    end
                    busy_cnt = 0;
                end
                if (have_cur) begin
                    checks++;
                    if (q !== cur.q || ovf !== cur.ovf) begin
                        failures++;
                        $display("FAIL result: got q=%h ovf=%b want q=%h ovf=%b", q, ovf, cur.q, cur.ovf);
                    end
                end
            end else begin
                in_done = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Drive START for one edge with the given operands.
    task automatic issue(input logic [15:0] ta, input logic [7:0] tn);
        @(posedge ck); #1;
        start = 1'b1; a = ta; n = tn;
        @(posedge ck); #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for DONE at a negedge.
    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 600) begin
            @(negedge ck);
            k++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: DONE not seen within %0d cycles", name, k);
        end
    endtask

    // ACK after `dly` extra held cycles, then confirm the block is idle with Q retained.
    task automatic finish_job(input string name, input int dly, input logic [15:0] want_q);
        repeat (dly) @(negedge ck);
        ack = 1'b1;
        @(posedge ck); #1;
        ack = 1'b0;
        @(negedge ck);
        check({name, "_idle"}, {30'd0, busy, done}, 32'd0);
        check({name, "_q_kept"}, {16'd0, q}, {16'd0, want_q});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        clr = 1'b1; start = 1'b0; a = '0; n = '0; ack = 1'b0;
        @(posedge ck); #1;
        clr = 1'b0;
        @(negedge ck);
        check("reset_state", {13'd0, busy, done, ovf, q}, 32'd0);

        // Basic job: 3 x 5 = 15, ACK raised as soon as DONE is seen.
        exp_q.push_back('{q: 16'h000F, ovf: 1'b0, busy: 9'd5});
        issue(16'd3, 8'd5);
        wait_done("basic");
        finish_job("basic", 0, 16'h000F);

        // Zero count: straight to HOLD with a cleared accumulator.
        exp_q.push_back('{q: 16'h0000, ovf: 1'b0, busy: 9'd0});
        issue(16'h1234, 8'd0);
        @(negedge ck);
        check("zero_done_1edge", {31'd0, done}, 32'd1);
        wait_done("zero");
        finish_job("zero", 0, 16'h0000);

        // Overflow: 5 x 0x4000 = 0x14000 -> 0x4000 with carry recorded.
        exp_q.push_back('{q: 16'h4000, ovf: 1'b1, busy: 9'd5});
        issue(16'h4000, 8'd5);
        wait_done("ovf");
        finish_job("ovf", 1, 16'h4000);

        // Following job must start with OVF cleared.
        exp_q.push_back('{q: 16'h0001, ovf: 1'b0, busy: 9'd1});
        issue(16'd1, 8'd1);
        wait_done("after_ovf");
        finish_job("after_ovf", 0, 16'h0001);

        // Ignored inputs: START/A change during RUN, START with ACK in HOLD.
        exp_q.push_back('{q: 16'h0008, ovf: 1'b0, busy: 9'd4});
        @(posedge ck); #1;
        start = 1'b1; a = 16'd2; n = 8'd4;
        @(posedge ck); #1;          // E0 accepted
        start = 1'b0;
        @(posedge ck); #1;          // after E1: RUN cycle 2
        start = 1'b1; a = 16'd7; n = 8'd9;
        @(posedge ck); #1;
        start = 1'b0;
        wait_done("ignore");
        ack = 1'b1; start = 1'b1; a = 16'd5; n = 8'd3;
        @(posedge ck); #1;
        ack = 1'b0; start = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge ck);
            if (busy || done) cnt++;
        end
        check("hold_start_ignored", cnt, 32'd0);
        check("ignore_q_kept", {16'd0, q}, 32'h0008);

        // ACK held high before DONE: exactly one DONE cycle.
        exp_q.push_back('{q: 16'h0006, ovf: 1'b0, busy: 9'd2});
        ack = 1'b1;
        issue(16'd3, 8'd2);
        wait_done("early_ack");
        @(negedge ck);
        check("early_ack_done_1cyc", {30'd0, busy, done}, 32'd0);
        ack = 1'b0;

        // Reset mid-run: CLR sampled at edge 50 of a 200-add job; no DONE.
        @(posedge ck); #1;
        start = 1'b1; a = 16'd1; n = 8'd200;
        @(posedge ck); #1;          // E0
        start = 1'b0;
        repeat (49) @(posedge ck);
        #1 clr = 1'b1;
        @(posedge ck); #1;          // E50 samples CLR
        clr = 1'b0;
        @(negedge ck);
        check("clr_midrun_state", {13'd0, busy, done, ovf, q}, 32'd0);
        cnt = 0;
        repeat (260) begin
            @(negedge ck);
            if (done || busy) cnt++;
        end
        check("clr_no_done", cnt, 32'd0);

        // Max count: 255 x 0x0101 = 0xFFFF, held 10 cycles with ACK low.
        exp_q.push_back('{q: 16'hFFFF, ovf: 1'b0, busy: 9'd255});
        issue(16'h0101, 8'd255);
        wait_done("max");
        cnt = 0;
        repeat (10) begin
            @(negedge ck);
            if (done) cnt++;
        end
        check("max_hold_10", cnt, 32'd10);
        finish_job("max", 0, 16'hFFFF);

        @(negedge ck);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
